serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Multi-cycle, bit-serial WIDTH-bit add/subtract unit.
- Drives the codebase's 1-bit sum cell once per clock, LSB first, and shifts the sum bit into a result register.
- Carry is computed locally as the majority of the three inputs, since the sum cell provides no carry output.
- Serves as the area-minimal arithmetic path for the processor's multi-cycle ALU operations, sitting between operand latch and writeback.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 2.
- CW, 5, bit-counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- i_start  input  1  request a new operation; sampled only when not busy.
- i_sub  input  1  0 = A+B, 1 = A-B; sampled with i_start.
- i_opA  input  WIDTH  operand A; sampled with i_start.
- i_opB  input  WIDTH  operand B; sampled with i_start.
- o_busy  output  1  high while in RUN.
- o_done  output  1  one-cycle pulse when the result is valid.
- o_result  output  WIDTH  sum/difference; held until the next accepted start.
- o_carry  output  1  final carry out (for sub: 1 = no borrow).
- o_ovf  output  1  signed overflow.

Behaviour:
- Interface: one clock (clk); reset rstn is asynchronous, active-low.
- Reset (async, any state): state=IDLE, counter=0, carry=0, operand shift registers=0, o_result=0, o_carry=0, o_ovf=0, o_busy=0, o_done=0.
- States and transitions:
  - IDLE: on an edge with i_start=1, go to RUN.
  - RUN: stays in RUN while counter < WIDTH-1; on the edge processing bit WIDTH-1, go to DONE.
  - DONE: with i_start=1, go to RUN; otherwise go to IDLE.
- Start acceptance (edge with i_start=1 in IDLE or DONE):
  - latch opA into shift register A.
  - latch (i_sub ? ~opB : opB) into shift register B.
  - carry = i_sub; counter = 0; clear o_result, o_carry, o_ovf.
- i_start during RUN is ignored entirely; operands and the operation are not disturbed.
- RUN, each edge:
  - sum cell inputs: A=regA[0], B=regB[0], I=carry.
  - o_result shifts right with the sum bit entering the MSB.
  - carry <= maj(regA[0], regB[0], carry).
  - regA and regB shift right; counter increments.
- At the last bit (counter=WIDTH-1):
  - o_carry <= new carry.
  - o_ovf <= (carry into MSB) XOR (new carry).
- Latency: start sampled at edge 0; bits are processed on edges 1..WIDTH; o_done=1 during the cycle after edge WIDTH. The result is valid whenever o_done=1 and remains valid through IDLE.
- o_busy=1 exactly in RUN (WIDTH cycles). o_done=1 exactly in DONE (1 cycle). The two are never high together.
- Back-to-back: a start accepted in DONE gives a done-to-next-busy gap of 0 cycles; the new operation's done pulse arrives WIDTH+1 cycles later.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.
- Counter wrap: the counter is never incremented past WIDTH-1; it is reloaded at start.
- Reset asserted mid-RUN aborts the operation with no done pulse. After release the block sits in IDLE with all outputs 0.

Test Plan:
- Reset, then start add 0x1234+0x0001 -> o_busy high 16 cycles; o_done pulses 1 cycle; o_result=0x1235, carry=0, ovf=0.
- Add 0xFFFF+0x0001 -> result 0x0000, carry=1, ovf=0. Add 0x7FFF+0x0001 -> result 0x8000, carry=0, ovf=1.
- Sub 0x0005-0x0007 -> result 0xFFFE, carry=0 (borrow), ovf=0. Sub 0x8000-0x0001 -> result 0x7FFF, carry=1, ovf=1.
- Pulse i_start with different operands on RUN cycle 5 -> ignored; original result is delivered at the original done time.
- Start in the DONE cycle with 0x0002+0x0003 -> busy rises the next cycle; second done arrives 17 cycles after the first, with result 0x0005. The first result is held until that start edge.
- Assert rstn=0 on RUN cycle 8 -> outputs 0 immediately (async); no o_done. After release, a fresh add 0x00FF+0x0001 gives 0x0100.

Source files
------------

// File: rtl/serial_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit add/subtract unit. One result bit per
//                clock, LSB first; carry regenerated locally as a majority
//                function because the 1-bit sum cell has no carry output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_opA,
    input  logic [WIDTH-1:0] i_opB,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_ovf
);

    localparam logic [1:0]    c_idle = 2'd0;
    localparam logic [1:0]    c_run  = 2'd1;
    localparam logic [1:0]    c_done = 2'd2;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_sum;
    logic             w_cout;

    // A start is only honoured when no operation is in flight
    assign w_accept = i_start && ((r_state == c_idle) || (r_state == c_done));
    assign w_last   = (r_cnt == c_last);

    // One-bit sum cell and the majority carry that accompanies it
    assign w_sum  = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cout = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  w_next = i_start ? c_run : c_idle;
            c_run:   w_next = w_last ? c_done : c_run;
            c_done:  w_next = i_start ? c_run : c_idle;
            default: w_next = c_idle;
        endcase
    end

    // Status outputs decoded directly from the state
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            c_run:   o_busy = 1'b1;
            c_done:  o_done = 1'b1;
            default: ;
        endcase
    end

    // Serial datapath: operand load on start, one bit per RUN cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1
            r_a         <= i_opA;
            r_b         <= i_sub ? ~i_opB : i_opB;
            r_carry     <= i_sub;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (r_state == c_run) begin
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_carry  <= w_cout;
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            if (w_last) begin
                // r_carry here is the carry into the MSB
                r_carry_out <= w_cout;
                r_ovf       <= r_carry ^ w_cout;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_result = r_result;
    assign o_carry  = r_carry_out;
    assign o_ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (table vectors, random
//                operations against an arithmetic model, multi-cycle corners).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic        clk;
    logic        rstn;
    logic        i_start;
    logic        i_sub;
    logic [15:0] i_opA;
    logic [15:0] i_opB;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_result;
    logic        o_carry;
    logic        o_ovf;

    int n_pass;
    int n_tot;
    int n_viol;

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[6];

    serial_adder #(.WIDTH(16), .CW(5)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_start  (i_start),
        .i_sub    (i_sub),
        .i_opA    (i_opA),
        .i_opB    (i_opB),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result),
        .o_carry  (o_carry),
        .o_ovf    (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // busy and done must never be high together
    always @(negedge clk) begin
        if (o_busy && o_done) n_viol++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Plain-arithmetic reference: 17-bit sum gives carry, sign rules give overflow
    function automatic void model(input logic sub, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c, output logic v);
        logic [16:0] full;
        logic [15:0] bb;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + 17'(sub);
        r    = full[15:0];
        c    = full[16];
        if (sub) v = (a[15] != b[15]) && (r[15] != a[15]);
        else     v = (a[15] == b[15]) && (r[15] != a[15]);
    endfunction

    task automatic run_check(input logic sub, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] er, input logic ec, input logic ev, input string tag);
        int busy_n;
        bit seen;
        busy_n = 0;
        seen   = 0;
        @(negedge clk);
        i_start = 1'b1; i_sub = sub; i_opA = a; i_opB = b;
        @(negedge clk);
        i_start = 1'b0;
        // operands change after acceptance; the result must not care
        i_sub = 1'($urandom); i_opA = 16'($urandom); i_opB = 16'($urandom);
        for (int k = 0; k < 40 && !seen; k++) begin
            if (o_busy) busy_n++;
            if (o_done) seen = 1;
            else @(negedge clk);
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " busy_cycles"}, busy_n, 16);
        chk({tag, " result"}, o_result, er);
        chk({tag, " carry"}, o_carry, ec);
        chk({tag, " ovf"}, o_ovf, ev);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, o_done, 1'b0);
        chk({tag, " result_held"}, o_result, er);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] er;
        logic        ec;
        logic        ev;
        logic        rs;
        int          n;
        bit          seen;

        n_pass = 0; n_tot = 0; n_viol = 0;
        rstn = 1'b0; i_start = 1'b0; i_sub = 1'b0; i_opA = '0; i_opB = '0;

        vecs[0] = '{1'b0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy", o_busy, 1'b0);
        chk("reset done", o_done, 1'b0);
        chk("reset result", o_result, 16'h0);
        chk("reset carry", o_carry, 1'b0);
        chk("reset ovf", o_ovf, 1'b0);
        rstn = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            run_check(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c, vecs[i].v,
                      $sformatf("vec%0d", i));
        end

        // Random operations against the model
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            model(rs, ra, rb, er, ec, ev);
            run_check(rs, ra, rb, er, ec, ev, $sformatf("rand%0d", i));
        end

        // Start during RUN is ignored
        @(negedge clk);
        i_start = 1'b1; i_sub = 1'b0; i_opA = 16'h1111; i_opB = 16'h2222;
        @(negedge clk);
        i_start = 1'b0; n = 1;
        repeat (4) begin @(negedge clk); n++; end
        i_start = 1'b1; i_sub = 1'b1; i_opA = 16'hFFFF; i_opB = 16'h0001;
        @(negedge clk);
        n++; i_start = 1'b0;
        while (!o_done && n < 60) begin @(negedge clk); n++; end
        chk("ignore done_time", n, 17);
        chk("ignore result", o_result, 16'h3333);
        chk("ignore carry", o_carry, 1'b0);
        chk("ignore ovf", o_ovf, 1'b0);
        @(negedge clk);
        chk("ignore back_idle", {o_busy, o_done}, 2'b00);

        // Back-to-back start in the DONE cycle
        @(negedge clk);
        i_start = 1'b1; i_sub = 1'b0; i_opA = 16'h1000; i_opB = 16'h0200;
        @(negedge clk);
        i_start = 1'b0; n = 1;
        while (!o_done && n < 60) begin @(negedge clk); n++; end
        chk("b2b first done_time", n, 17);
        chk("b2b first result", o_result, 16'h1200);
        i_start = 1'b1; i_sub = 1'b0; i_opA = 16'h0002; i_opB = 16'h0003;
        #1;
        chk("b2b held before edge", o_result, 16'h1200);
        @(negedge clk);
        i_start = 1'b0; n = 1;
        chk("b2b busy next cycle", o_busy, 1'b1);
        chk("b2b done dropped", o_done, 1'b0);
        while (!o_done && n < 60) begin @(negedge clk); n++; end
        chk("b2b done spacing", n, 17);
        chk("b2b second result", o_result, 16'h0005);
        chk("b2b second carry", o_carry, 1'b0);
        chk("b2b second ovf", o_ovf, 1'b0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        i_start = 1'b1; i_sub = 1'b0; i_opA = 16'hAAAA; i_opB = 16'h1111;
        @(negedge clk);
        i_start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("abort busy", o_busy, 1'b0);
        chk("abort done", o_done, 1'b0);
        chk("abort result", o_result, 16'h0);
        chk("abort carry", o_carry, 1'b0);
        chk("abort ovf", o_ovf, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_done || o_busy) seen = 1;
        end
        chk("abort stays idle", 32'(seen), 32'd0);
        run_check(1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, "post_reset");

        chk("busy_done_exclusive", n_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
